dfe_out_buffer: RTL and testbench

- Output rate buffer directly downstream of the filter core. It accepts the core's decimated sample stream and stores each sample with per-sample overflow/underflow tags in a FIFO.
- It delivers samples to the downstream consumer over a valid/ready handshake, so consumer stalls do not lose data.
- It reports fill level, almost-full and dropped-sample status.

---
 rtl/dfe_out_pkg.sv | 16 +
 rtl/dfe_out_fifo_mem.sv | 28 ++
 rtl/dfe_out_buffer.sv | 162 ++++++++++++++++
 tb/tb_dfe_out_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfe_out_pkg.sv
// Shared types for the DFE output rate buffer: FIFO entry layout and drop counter width.
package dfe_out_pkg;

  localparam int unsigned OUT_DATA_W = 16;
  localparam int unsigned DROP_CNT_W = 16;

  // One stored sample with its saturation tags.
  typedef struct packed {
    logic signed [OUT_DATA_W-1:0] data;
    logic                         ovf;
    logic                         unf;
  } out_entry_t;

  localparam int unsigned ENTRY_W = $bits(out_entry_t);

endpackage : dfe_out_pkg

// File: rtl/dfe_out_fifo_mem.sv
// Simple dual-port register array for the output buffer: one synchronous write, one
// combinational read. Storage is intentionally unreset.
module dfe_out_fifo_mem #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read port.
  assign rdata = mem[raddr];

endmodule : dfe_out_fifo_mem

// File: rtl/dfe_out_buffer.sv
// DFE output rate buffer: FIFO between the filter core and a valid/ready consumer.
// Head entry, level, almost_full and drop status are all registered.
// Optional feature: define OUT_BUF_DROP_CNT_EN to add a saturating 16-bit drop_count output.
module dfe_out_buffer
  import dfe_out_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned AF_THRESH  = 12,
  localparam int unsigned LVL_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         ovf_in,
  input  logic                         unf_in,
  input  logic                         flush,
  input  logic                         ready_in,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         ovf_out,
  output logic                         unf_out,
  output logic [LVL_WIDTH-1:0]         level,
  output logic                         almost_full,
`ifdef OUT_BUF_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]        drop_count,
`endif
  output logic                         drop_sticky
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [LVL_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LVL_WIDTH-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [LVL_WIDTH-1:0] level_nxt;
  logic                 valid_nxt;
  logic                 af_nxt;
  logic                 sticky_nxt;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 we;
  out_entry_t           wentry;
  out_entry_t           rentry;
  out_entry_t           head_nxt;
  logic [ENTRY_W-1:0]   rdata;

`ifdef OUT_BUF_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_nxt;
`endif

  // Sample storage.
  dfe_out_fifo_mem #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wentry),
    .raddr (rd_ptr_nxt[ADDR_W-1:0]),
    .rdata (rdata)
  );

  assign rentry = out_entry_t'(rdata);

  // Next-state pointers, flags and head entry.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    sticky_nxt   = drop_sticky;
    we           = 1'b0;
    wentry.data  = data_in;
    wentry.ovf   = ovf_in;
    wentry.unf   = unf_in;
    head_nxt.data = data_out;
    head_nxt.ovf  = ovf_out;
    head_nxt.unf  = unf_out;
`ifdef OUT_BUF_DROP_CNT_EN
    drop_cnt_nxt = drop_count;
`endif

    full = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
           (wr_ptr[LVL_WIDTH-1] != rd_ptr[LVL_WIDTH-1]);
    pop  = valid_out && ready_in;
    push = valid_in && (!full || pop);
    drop = valid_in && full && !pop;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      sticky_nxt = 1'b0;
`ifdef OUT_BUF_DROP_CNT_EN
      drop_cnt_nxt = '0;
`endif
    end else begin
      if (push) begin
        we         = 1'b1;
        wr_ptr_nxt = wr_ptr + LVL_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + LVL_WIDTH'(1);
      end
      if (drop) begin
        sticky_nxt = 1'b1;
`ifdef OUT_BUF_DROP_CNT_EN
        if (drop_count != {DROP_CNT_W{1'b1}}) begin
          drop_cnt_nxt = drop_count + DROP_CNT_W'(1);
        end
`endif
      end
    end

    level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    valid_nxt = (wr_ptr_nxt != rd_ptr_nxt);
    af_nxt    = (level_nxt >= LVL_WIDTH'(AF_THRESH));

    // The next head is either already stored or is being written on this edge.
    if (valid_nxt) begin
      if (push && (rd_ptr_nxt == wr_ptr)) begin
        head_nxt = wentry;
      end else begin
        head_nxt = rentry;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      ovf_out     <= 1'b0;
      unf_out     <= 1'b0;
      level       <= '0;
      almost_full <= 1'b0;
      drop_sticky <= 1'b0;
`ifdef OUT_BUF_DROP_CNT_EN
      drop_count  <= '0;
`endif
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      valid_out   <= valid_nxt;
      data_out    <= head_nxt.data;
      ovf_out     <= head_nxt.ovf;
      unf_out     <= head_nxt.unf;
      level       <= level_nxt;
      almost_full <= af_nxt;
      drop_sticky <= sticky_nxt;
`ifdef OUT_BUF_DROP_CNT_EN
      drop_count  <= drop_cnt_nxt;
`endif
    end
  end

endmodule : dfe_out_buffer

// File: tb/tb_dfe_out_buffer.sv
// Self-checking bench for dfe_out_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_dfe_out_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] data_in = '0;
  logic                 ovf_in = 1'b0;
  logic                 unf_in = 1'b0;
  logic                 flush = 1'b0;
  logic                 ready_in = 1'b0;
  logic                 valid_out;
  logic signed [DW-1:0] data_out;
  logic                 ovf_out;
  logic                 unf_out;
  logic [LW-1:0]        level;
  logic                 almost_full;
  logic                 drop_sticky;
`ifdef OUT_BUF_DROP_CNT_EN
  logic [15:0]          drop_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: queue of {data, ovf, unf}.
  logic [DW+1:0] mq[$];
  bit            m_sticky = 0;
  int            m_drops = 0;
  bit            m_pop;
  bit            m_acc;
  logic [DW-1:0] got[$];

  dfe_out_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AFT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ovf_in      (ovf_in),
    .unf_in      (unf_in),
    .flush       (flush),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .ovf_out     (ovf_out),
    .unf_out     (unf_out),
    .level       (level),
    .almost_full (almost_full),
`ifdef OUT_BUF_DROP_CNT_EN
    .drop_count  (drop_count),
`endif
    .drop_sticky (drop_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO semantics from the rules (pop if non-empty and ready; accept if room or popping).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      mq.delete();
      m_sticky = 0;
      m_drops  = 0;
    end else begin
      m_pop = (mq.size() > 0) && ready_in;
      m_acc = valid_in && ((mq.size() < DEPTH) || m_pop);
      if (valid_in && !m_acc) begin
        m_sticky = 1;
        if (m_drops < 65535) m_drops++;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back({data_in, ovf_in, unf_in});
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", 32'(valid_out), 32'(mq.size() != 0));
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_af", 32'(almost_full), 32'(mq.size() >= AFT));
      chk("m_sticky", 32'(drop_sticky), 32'(m_sticky));
`ifdef OUT_BUF_DROP_CNT_EN
      chk("m_dropcnt", 32'(drop_count), 32'(m_drops));
`endif
      if (mq.size() != 0) begin
        chk("m_head", 32'({data_out, ovf_out, unf_out}), 32'(mq[0]));
      end
      if (valid_out && ready_in) got.push_back(data_out);
    end
  end

  task automatic drive(input bit v, input int d, input bit o, input bit u,
                       input bit r, input bit f);
    valid_in = v;
    data_in  = DW'(d);
    ovf_in   = o;
    unf_in   = u;
    ready_in = r;
    flush    = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(valid_out), 0);
    chk({tag, "_data"}, 32'($unsigned(data_out)), 0);
    chk({tag, "_ovf"}, 32'(ovf_out), 0);
    chk({tag, "_unf"}, 32'(unf_out), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_sticky"}, 32'(drop_sticky), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single sample, then pop.
    drive(1, 16'h1234, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_valid", 32'(valid_out), 1);
    chk("t1_data", 32'($unsigned(data_out)), 32'h1234);
    chk("t1_ovf", 32'(ovf_out), 1);
    chk("t1_unf", 32'(unf_out), 0);
    chk("t1_level", 32'(level), 1);
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("t1_pop_valid", 32'(valid_out), 0);
    chk("t1_pop_level", 32'(level), 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Fill with backpressure, then a dropped sample.
    got.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1, i, i[0], i[1], 0, 0);
      tick();
      if (i == 10) chk("fill_af_lo", 32'(almost_full), 0);
      if (i == 11) chk("fill_af_hi", 32'(almost_full), 1);
    end
    chk("fill_level", 32'(level), 16);
    chk("fill_sticky0", 32'(drop_sticky), 0);
    drive(1, 99, 0, 0, 0, 0);
    tick();
    chk("drop_sticky", 32'(drop_sticky), 1);
    chk("drop_level", 32'(level), 16);

    // Full with simultaneous push and pop.
    drive(1, 100, 0, 0, 1, 0);
    tick();
    chk("fpp_level", 32'(level), 16);
    chk("fpp_sticky", 32'(drop_sticky), 1);
    chk("fpp_head", 32'($unsigned(data_out)), 1);

    // Drain.
    drive(0, 0, 0, 0, 1, 0);
    n = 0;
    while (valid_out && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(valid_out), 0);
    chk("drain_count", 32'(got.size()), 17);
    if (got.size() == 17) begin
      for (int i = 0; i < 16; i++) chk("drain_order", 32'(got[i]), 32'(i));
      chk("drain_last", 32'(got[16]), 100);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Streaming with wrap-around; one-cycle latency, level stays at 1.
    for (int i = 0; i < 40; i++) begin
      drive(1, (i == 7) ? 16'h8001 : i, 0, i[2], 1, 0);
      tick();
      chk("strm_valid", 32'(valid_out), 1);
      chk("strm_data", 32'($unsigned(data_out)), (i == 7) ? 32'h8001 : 32'(i));
      chk("strm_unf", 32'(unf_out), 32'(i[2]));
      chk("strm_level", 32'(level), 1);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("strm_empty", 32'(valid_out), 0);
    drive(0, 0, 0, 0, 0, 0);

    // Flush at level 5 with drop_sticky set; concurrent push/pop ignored.
    for (int i = 0; i < 5; i++) begin
      drive(1, 200 + i, 0, 0, 0, 0);
      tick();
    end
    chk("fl_level5", 32'(level), 5);
    chk("fl_sticky1", 32'(drop_sticky), 1);
    drive(1, 77, 0, 0, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("fl_valid", 32'(valid_out), 0);
    chk("fl_level", 32'(level), 0);
    chk("fl_sticky", 32'(drop_sticky), 0);
    tick();

`ifdef OUT_BUF_DROP_CNT_EN
    // Saturating drop counter.
    for (int i = 0; i < 21; i++) begin
      drive(1, 300 + i, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("dc_level", 32'(level), 16);
    chk("dc_count", 32'(drop_count), 5);
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("dc_flush", 32'(drop_count), 0);
    tick();
`endif

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 40 + i, 1, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("ar_level3", 32'(level), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("ar");
`ifdef OUT_BUF_DROP_CNT_EN
    chk("ar_dropcnt", 32'(drop_count), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", 32'(valid_out), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dfe_out_buffer
